// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts register-register instructions, drives a combinational ALU,
// and writes results back to an internal register file. Optional flags via ALU_FLAGS_EN.
module alu_issue_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_N  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       instr_valid,
  output logic                       instr_ready,
  input  logic [15:0]                instr,
  input  logic                       wr_en,
  input  logic [$clog2(REG_N)-1:0]   wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [$clog2(REG_N)-1:0]   dbg_addr,
  output logic [DATA_W-1:0]          dbg_data,
  output logic [DATA_W-1:0]          alu_a,
  output logic [DATA_W-1:0]          alu_b,
  output logic [2:0]                 alu_op,
  input  logic [DATA_W-1:0]          alu_res,
  output logic                       done,
  output logic                       illegal
`ifdef ALU_FLAGS_EN
  ,
  output logic                       flag_z,
  output logic                       flag_n
`endif
);

  localparam int unsigned AW   = $clog2(REG_N);
  localparam int unsigned OP_W = 3;
  localparam logic [OP_W-1:0] OP_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t            state;
  logic [OP_W-1:0]   op_q;
  logic [AW-1:0]     rd_q;
  logic [AW-1:0]     rs1_q;
  logic [AW-1:0]     rs2_q;
  logic [DATA_W-1:0] res_q;
  logic [DATA_W-1:0] regs [REG_N];
  logic              accept_c;
  logic              unused_instr_bits;

  assign accept_c          = instr_valid && instr_ready;
  assign dbg_data          = regs[dbg_addr];
  assign unused_instr_bits = ^instr[3:0];

  // Sequencer, register file and ALU interface; WB write is last so it beats a host write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      instr_ready <= 1'b1;
      done        <= 1'b0;
      illegal     <= 1'b0;
      op_q        <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      res_q       <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
`ifdef ALU_FLAGS_EN
      flag_z      <= 1'b0;
      flag_n      <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      if (wr_en) regs[wr_addr] <= wr_data;
      case (state)
        IDLE: begin
          if (accept_c) begin
            op_q  <= instr[15:13];
            rd_q  <= AW'(instr[12:10]);
            rs1_q <= AW'(instr[9:7]);
            rs2_q <= AW'(instr[6:4]);
            if (instr[15:13] == OP_ILLEGAL) begin
              illegal <= 1'b1;
            end else begin
              state       <= READ;
              instr_ready <= 1'b0;
            end
          end
        end
        READ: begin
          alu_a  <= regs[rs1_q];
          alu_b  <= regs[rs2_q];
          alu_op <= op_q;
          state  <= EXEC;
        end
        EXEC: begin
          res_q <= alu_res;
          state <= WB;
        end
        WB: begin
          regs[rd_q]  <= res_q;
          done        <= 1'b1;
          instr_ready <= 1'b1;
          state       <= IDLE;
`ifdef ALU_FLAGS_EN
          flag_z      <= (res_q == '0);
          flag_n      <= res_q[DATA_W-1];
`endif
        end
        default: begin
          state       <= IDLE;
          instr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU stub.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [15:0] alu_a, alu_b, alu_res;
  logic [2:0]  alu_op;
  logic        done, illegal;
`ifdef ALU_FLAGS_EN
  logic        flag_z, flag_n;
`endif

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
    .done(done), .illegal(illegal)
`ifdef ALU_FLAGS_EN
    , .flag_z(flag_z), .flag_n(flag_n)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      3'd0:    alu_res = alu_a + alu_b;
      3'd1:    alu_res = alu_a - alu_b;
      3'd2:    alu_res = alu_a & alu_b;
      default: alu_res = alu_a | alu_b;
    endcase
  end

  typedef struct packed {
    logic        ill;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 4'h0};
  endfunction

  function automatic exp_t mk(input logic ill, input logic [2:0] op, input logic [15:0] a,
                              input logic [15:0] b, input logic [15:0] res);
    exp_t e;
    e.ill = ill; e.op = op; e.a = a; e.b = b; e.res = res;
    return e;
  endfunction

  // Monitor: every done/illegal pulse must match the oldest expected event
  always @(negedge clk) begin
    if (rst_n && (done || illegal)) begin
      chk("done_illegal_exclusive", 32'(done && illegal), 32'd0);
      if (sbq.size() == 0) begin
        chk("unexpected_event", 32'd1, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("event_kind_illegal", 32'(illegal), 32'(mon_e.ill));
        if (!mon_e.ill) begin
          chk("alu_a", 32'(alu_a), 32'(mon_e.a));
          chk("alu_b", 32'(alu_b), 32'(mon_e.b));
          chk("alu_op", 32'(alu_op), 32'(mon_e.op));
          chk("alu_res", 32'(alu_res), 32'(mon_e.res));
        end
      end
    end
  end

  task automatic host_wr(input logic [2:0] addr, input logic [15:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] addr, input logic [15:0] exp);
    dbg_addr = addr;
    #1;
    chk(name, 32'(dbg_data), 32'(exp));
  endtask

  // Called at a negedge; returns 1ns after the accepting edge
  task automatic issue(input logic [15:0] ins, input exp_t e, input bit push);
    int guard = 0;
    while (!instr_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_issue", 32'(instr_ready), 32'd1);
    instr = ins; instr_valid = 1'b1;
    if (push) sbq.push_back(e);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic wait_evt(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(done || illegal) && lat < 12);
    if (!(done || illegal)) lat = 99;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acc;
    int dcnt;
    int dt[$];
    logic rdy;
    instr_valid = 1'b0; instr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; dbg_addr = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(instr_ready), 32'd1);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_illegal", 32'(illegal), 32'd0);
    chk("reset_alu_a", 32'(alu_a), 32'd0);
    chk("reset_alu_b", 32'(alu_b), 32'd0);
    chk("reset_alu_op", 32'(alu_op), 32'd0);
    for (int i = 0; i < 8; i++) rd_chk("reset_reg", 3'(i), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD r3 = r1 + r2
    host_wr(3'd1, 16'h006A);
    host_wr(3'd2, 16'h003B);
    rd_chk("host_wr_r1", 3'd1, 16'h006A);
    issue(enc(3'd0, 3'd3, 3'd1, 3'd2), mk(1'b0, 3'd0, 16'h006A, 16'h003B, 16'h00A5), 1'b1);
    wait_evt(lat);
    chk("add_latency", 32'(lat), 32'd4);
    rd_chk("add_r3", 3'd3, 16'h00A5);
    chk("ready_after_done", 32'(instr_ready), 32'd1);

    // SUB r1 = r2 - r1, rd aliases rs2
    issue(enc(3'd1, 3'd1, 3'd2, 3'd1), mk(1'b0, 3'd1, 16'h003B, 16'h006A, 16'hFFD1), 1'b1);
    wait_evt(lat);
    chk("sub_latency", 32'(lat), 32'd4);
    rd_chk("sub_r1", 3'd1, 16'hFFD1);
`ifdef ALU_FLAGS_EN
    chk("sub_flag_n", 32'(flag_n), 32'd1);
    chk("sub_flag_z", 32'(flag_z), 32'd0);
`endif

    // Illegal opcode
    issue(enc(3'd7, 3'd2, 3'd1, 3'd1), mk(1'b1, 3'd7, 16'h0, 16'h0, 16'h0), 1'b1);
    wait_evt(lat);
    chk("illegal_latency", 32'(lat), 32'd1);
    chk("illegal_ready", 32'(instr_ready), 32'd1);
    @(negedge clk);
    chk("illegal_one_cycle", 32'(illegal), 32'd0);
    chk("illegal_no_done", 32'(done), 32'd0);
    rd_chk("illegal_r2_kept", 3'd2, 16'h003B);
    rd_chk("illegal_r1_kept", 3'd1, 16'hFFD1);
    chk("illegal_alu_op_held", 32'(alu_op), 32'd1);
`ifdef ALU_FLAGS_EN
    chk("illegal_flag_n_held", 32'(flag_n), 32'd1);
`endif

    // Host write coinciding with accept: READ sees the new r2
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0010;
    issue(enc(3'd2, 3'd4, 3'd1, 3'd2), mk(1'b0, 3'd2, 16'hFFD1, 16'h0010, 16'h0010), 1'b1);
    wait_evt(lat);
    chk("and_latency", 32'(lat), 32'd4);
    rd_chk("and_r4", 3'd4, 16'h0010);
    rd_chk("and_r2_new", 3'd2, 16'h0010);

    // Host write to rd in the WB cycle loses to writeback
    @(negedge clk);
    issue(enc(3'd3, 3'd5, 3'd3, 3'd4), mk(1'b0, 3'd3, 16'h00A5, 16'h0010, 16'h00B5), 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    @(negedge clk);
    chk("or_done_timing", 32'(done), 32'd1);
    rd_chk("wb_beats_host_r5", 3'd5, 16'h00B5);

    // Valid held 8 cycles with two dependent instructions
    @(negedge clk);
    acc = 0; dcnt = 0;
    instr = enc(3'd0, 3'd6, 3'd3, 3'd4); instr_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      rdy = instr_ready;
      if (c == 8) instr_valid = 1'b0;
      if (instr_valid && rdy) begin
        acc++;
        if (acc == 1) sbq.push_back(mk(1'b0, 3'd0, 16'h00A5, 16'h0010, 16'h00B5));
        else sbq.push_back(mk(1'b0, 3'd1, 16'h00B5, 16'h00A5, 16'h0010));
      end
      @(posedge clk);
      #1;
      if (acc == 1) instr = enc(3'd1, 3'd7, 3'd6, 3'd3);
      @(negedge clk);
      if (done) begin
        dcnt++;
        dt.push_back(c);
      end
    end
    chk("b2b_accepts", 32'(acc), 32'd2);
    chk("b2b_dones", 32'(dcnt), 32'd2);
    if (dt.size() == 2) begin
      chk("b2b_first_done", 32'(dt[0]), 32'd3);
      chk("b2b_spacing", 32'(dt[1] - dt[0]), 32'd4);
    end
    rd_chk("b2b_r6", 3'd6, 16'h00B5);
    rd_chk("b2b_r7", 3'd7, 16'h0010);

    // Reset asserted while in EXEC aborts the instruction
    @(negedge clk);
    issue(enc(3'd0, 3'd0, 3'd1, 3'd2), mk(1'b0, 3'd0, 16'h0, 16'h0, 16'h0), 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    sbq.delete();
    #1;
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ready", 32'(instr_ready), 32'd1);
    chk("abort_alu_a", 32'(alu_a), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort_no_done", 32'(dcnt), 32'd0);
    chk("abort_idle_ready", 32'(instr_ready), 32'd1);
    rd_chk("abort_r0", 3'd0, 16'h0000);
    rd_chk("abort_r1", 3'd1, 16'h0000);

    // Post-reset operation with wrap-around add
    host_wr(3'd1, 16'h8001);
    host_wr(3'd2, 16'h8000);
    issue(enc(3'd0, 3'd3, 3'd1, 3'd2), mk(1'b0, 3'd0, 16'h8001, 16'h8000, 16'h0001), 1'b1);
    wait_evt(lat);
    chk("post_reset_latency", 32'(lat), 32'd4);
    rd_chk("post_reset_r3", 3'd3, 16'h0001);
`ifdef ALU_FLAGS_EN
    chk("wrap_flag_z", 32'(flag_z), 32'd0);
    chk("wrap_flag_n", 32'(flag_n), 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
